mult_operand_fifo: RTL and testbench
====================================

Name: mult_operand_fifo

Overview:
- Operand front-end for the serial multiplier: buffers (A, B) operand pairs arriving on a valid/ready interface in a small FIFO.
- Issues one pair at a time to the multiplier control path as a single-cycle ld_input pulse, with operands held stable.
- Blocks further issue until the multiplier reports done.
- Sits directly upstream of the multiplier control/datapath and drives its ld_input.

Parameters:
- WIDTH, 8, bit width of each operand.
- DEPTH, 4, number of operand-pair entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all logic on posedge.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- mult_ready  input  1  multiplier controller in READY state.
- mult_done  input  1  multiplier controller in DONE state (one-cycle).
- ld_input  output  1  registered one-cycle load pulse to multiplier.
- op_a  output  WIDTH  issued operand A, registered.
- op_b  output  WIDTH  issued operand B, registered.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Synchronous active-low reset on resetn, sampled at posedge clk:
  - Read/write pointers, count, busy flag: 0.
  - Outputs: ld_input=0, op_a=0, op_b=0, empty=1, full=0.
  - Stored entries are discarded.
- in_ready = resetn && !full. Combinational; there is no full-with-pop pass-through.
- Push: in_valid && in_ready at a clock edge writes {in_a, in_b} at the write pointer. The pointer wraps modulo DEPTH.
- Issue condition, evaluated each cycle: !empty && mult_ready && !busy.
- When the issue condition is true, the following happen at the next edge:
  - ld_input <= 1.
  - op_a/op_b <= head entry.
  - Read pointer advances (wraps).
  - busy <= 1.
- ld_input is high for exactly one cycle per issue, otherwise 0.
- op_a/op_b hold their value until the next issue. They are not cleared on done.
- busy clears at the edge where mult_done is sampled high while busy=1.
- Issue is not permitted in the same cycle that busy is cleared. The earliest next ld_input is 2 cycles after the mult_done cycle. The multiplier is in READY by then.
- busy blocks a second issue during the ld_input cycle, when the multiplier still shows mult_ready=1.
- mult_done while busy=0 is ignored.
- Simultaneous push and issue: count unchanged, both pointers advance.
- No bypass: a pair pushed into an empty FIFO at edge t produces ld_input at the earliest in cycle t+2. This requires mult_ready=1 and busy=0.
- count, full and empty are derived from a registered count and are updated at the same edge as the push/pop.
- Reset mid-operation drops the in-flight operation and all queued entries. The multiplier shares resetn and also returns to READY.
- Issue order is strictly FIFO.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with in_valid=1 -> in_ready=0, ld_input=0, count=0, empty=1, op_a=op_b=0.
- Single op: push (A=5, B=7) with mult_ready=1 -> ld_input pulses once, 2 cycles after accept, with op_a=5, op_b=7. Hold mult_ready=1 during the pulse -> no second pulse. count returns to 0.
- Back-to-back: push 3 pairs (1,2), (3,4), (5,6); model the multiplier with a 4-cycle OPERATE -> ld_input pulses in order 1/2, 3/4, 5/6. Each pulse occurs exactly 2 cycles after the preceding mult_done. Never 2 pulses between successive dones.
- Full: with mult_ready=0, push DEPTH=4 pairs -> full=1, in_ready=0, count=4. A 5th in_valid is not accepted. After a single issue and pop, in_ready=1 again.
- Wrap/simultaneous: keep the FIFO at count=2 while pushing and issuing in the same cycle for 10 operations -> count constant at the push+pop edges. All 10 pairs are issued in order across the pointer wrap.
- Reset mid-op: with busy=1 and 2 entries queued, assert resetn=0 for 1 cycle -> count=0, busy cleared. A new push after reset is issued normally. No stale entry is ever issued.

Source files
------------

// File: rtl/mult_operand_fifo.sv
// Operand front-end for the serial multiplier: queues (A, B) pairs and issues
// one pair at a time as a registered ld_input pulse, holding off until done.
module mult_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     mult_ready,
    input  logic                     mult_done,
    output logic                     ld_input,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               busy;
    logic               push;
    logic               issue;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    // No pass-through: a full FIFO refuses even when it pops this cycle.
    assign in_ready = resetn && !full;
    assign push     = in_valid && in_ready;
    // busy keeps a second issue out while the multiplier still shows mult_ready.
    assign issue    = !empty && mult_ready && !busy;

    // NOTE: storage has no reset; stale slots are unreachable once count is 0,
    // and leaving them unreset lets the array map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            ld_input <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            ld_input <= issue;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (issue) begin
                {op_a, op_b} <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + AW'(1);
                busy         <= 1'b1;
            end else if (busy && mult_done) begin
                busy <= 1'b0;
            end

            unique case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_operand_fifo.sv
// Self-checking bench for mult_operand_fifo: queue-based reference model plus a
// behavioural multiplier (READY -> OPERATE -> DONE) driven from the bench.
module tb_mult_operand_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int OP_CYC = 4;

    localparam int M_IDLE = 0;
    localparam int M_OP   = 1;
    localparam int M_DONE = 2;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   mult_ready;
    logic                   mult_done;
    logic                   ld_input;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;

    mult_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mult_ready (mult_ready),
        .mult_done  (mult_done),
        .ld_input   (ld_input),
        .op_a       (op_a),
        .op_b       (op_b),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [2*WIDTH-1:0] q[$];
    bit                 rbusy;
    bit                 exp_ld;
    logic [WIDTH-1:0]   exp_a;
    logic [WIDTH-1:0]   exp_b;

    // Multiplier model state
    bit model_on;
    int mst;
    int mcnt;
    int done_tick;
    int tick_no;

    int n_tests;
    int n_fail;

    // One clock: predict the coming edge from the rules, then step to the
    // following negedge where outputs are stable, then let the multiplier react.
    task automatic tick();
        bit acc;
        bit iss;
        bit rst_seen;
        rst_seen = resetn;
        if (!resetn) begin
            q.delete();
            rbusy  = 1'b0;
            exp_ld = 1'b0;
            exp_a  = '0;
            exp_b  = '0;
        end else begin
            iss    = (q.size() > 0) && mult_ready && !rbusy;
            acc    = in_valid && (q.size() < DEPTH);
            exp_ld = iss;
            if (iss) begin
                {exp_a, exp_b} = q.pop_front();
                rbusy = 1'b1;
            end else if (rbusy && mult_done) begin
                rbusy = 1'b0;
            end
            if (acc) q.push_back({in_a, in_b});
        end
        @(negedge clk);
        tick_no++;
        if (model_on) begin
            if (!rst_seen) begin
                mst        = M_IDLE;
                mult_done  = 1'b0;
                mult_ready = 1'b1;
            end else begin
                case (mst)
                    M_IDLE: if (ld_input) begin
                        mst  = M_OP;
                        mcnt = OP_CYC;
                    end
                    M_OP: begin
                        mult_ready = 1'b0;
                        mcnt--;
                        if (mcnt == 0) begin
                            mult_done = 1'b1;
                            done_tick = tick_no;
                            mst       = M_DONE;
                        end
                    end
                    default: begin
                        mult_done  = 1'b0;
                        mult_ready = 1'b1;
                        mst        = M_IDLE;
                    end
                endcase
            end
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        mst      = M_IDLE;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        in_valid   = 1'b1;
        in_a       = WIDTH'($urandom);
        in_b       = WIDTH'($urandom);
        mult_ready = 1'b1;
        mult_done  = 1'b0;
        repeat (2) tick();
        n_tests += 7;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        if (ld_input !== 1'b0) begin n_fail++; $display("FAIL reset_ld_input: got %b expected 0", ld_input); end
        if (count !== 0)       begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        if (op_a !== 0)        begin n_fail++; $display("FAIL reset_op_a: got %0d expected 0", op_a); end
        if (op_b !== 0)        begin n_fail++; $display("FAIL reset_op_b: got %0d expected 0", op_b); end
        resetn   = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    // Multiplier held in READY with no done: busy alone must stop a second pulse.
    task automatic test_single_op();
        int acc_tick;
        int pulses;
        model_on   = 1'b0;
        mult_ready = 1'b1;
        mult_done  = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_b     = 8'd7;
        tick();
        acc_tick = tick_no;
        in_valid = 1'b0;
        pulses   = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_tests++;
            if (ld_input !== exp_ld) begin n_fail++; $display("FAIL single_ld: tick %0d got %b expected %b", t, ld_input, exp_ld); end
            if (ld_input === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    // ld_input rises at the edge after the accepting edge
                    n_tests += 3;
                    if (tick_no - acc_tick != 1) begin n_fail++; $display("FAIL single_latency: got %0d edges expected 1", tick_no - acc_tick); end
                    if (op_a !== 8'd5) begin n_fail++; $display("FAIL single_op_a: got %0d expected 5", op_a); end
                    if (op_b !== 8'd7) begin n_fail++; $display("FAIL single_op_b: got %0d expected 7", op_b); end
                end
            end
        end
        n_tests += 3;
        if (pulses != 1)    begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        if (count !== 0)    begin n_fail++; $display("FAIL single_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] av[3];
        logic [WIDTH-1:0] bv[3];
        int got;
        int since_done;
        int last_done;
        av = '{8'd1, 8'd3, 8'd5};
        bv = '{8'd2, 8'd4, 8'd6};
        model_on   = 1'b1;
        mult_ready = 1'b1;
        mult_done  = 1'b0;
        done_tick  = -1;
        do_reset();
        got        = 0;
        since_done = 0;
        last_done  = -1;
        for (int t = 0; t < 80 && got < 3; t++) begin
            if (t < 3) begin
                in_valid = 1'b1;
                in_a     = av[t];
                in_b     = bv[t];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (done_tick != last_done) begin
                last_done  = done_tick;
                since_done = 0;
            end
            n_tests++;
            if (ld_input !== exp_ld) begin n_fail++; $display("FAIL b2b_ld: tick %0d got %b expected %b", t, ld_input, exp_ld); end
            if (ld_input === 1'b1) begin
                n_tests += 3;
                if (op_a !== av[got] || op_b !== bv[got]) begin
                    n_fail++;
                    $display("FAIL b2b_order: pulse %0d got %0d/%0d expected %0d/%0d", got, op_a, op_b, av[got], bv[got]);
                end
                if (got > 0 && tick_no - last_done != 2) begin
                    n_fail++;
                    $display("FAIL b2b_done_gap: pulse %0d got %0d cycles expected 2", got, tick_no - last_done);
                end
                if (since_done != 0) begin
                    n_fail++;
                    $display("FAIL b2b_double: pulse %0d got %0d extra pulses since done expected 0", got, since_done);
                end
                since_done++;
                got++;
            end
        end
        n_tests++;
        if (got != 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d pulses expected 3", got); end
        model_on = 1'b0;
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] fa;
        logic [WIDTH-1:0] fb;
        model_on   = 1'b0;
        mult_ready = 1'b0;
        mult_done  = 1'b0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            if (i == 0) begin
                fa = in_a;
                fb = in_b;
            end
            tick();
        end
        n_tests += 4;
        if (count !== DEPTH)   begin n_fail++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        if (full !== 1'b1)     begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        if (empty !== 1'b0)    begin n_fail++; $display("FAIL full_empty: got %b expected 0", empty); end
        in_a = WIDTH'($urandom);
        in_b = WIDTH'($urandom);
        tick();
        n_tests++;
        if (count !== DEPTH) begin n_fail++; $display("FAIL full_overflow: got count %0d expected %0d", count, DEPTH); end
        in_valid   = 1'b0;
        mult_ready = 1'b1;
        tick();
        mult_ready = 1'b0;
        n_tests += 5;
        if (ld_input !== 1'b1) begin n_fail++; $display("FAIL full_issue: got %b expected 1", ld_input); end
        if (op_a !== fa || op_b !== fb) begin n_fail++; $display("FAIL full_head: got %0d/%0d expected %0d/%0d", op_a, op_b, fa, fb); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again: got %b expected 1", in_ready); end
        if (count !== DEPTH-1) begin n_fail++; $display("FAIL full_pop_count: got %0d expected %0d", count, DEPTH-1); end
        if (full !== 1'b0)     begin n_fail++; $display("FAIL full_clear: got %b expected 0", full); end
    endtask

    // Alternate push+issue and done cycles so occupancy sits at 2 across the wrap.
    task automatic test_wrap();
        model_on   = 1'b0;
        mult_ready = 1'b0;
        mult_done  = 1'b0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            tick();
        end
        mult_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            tick();
            n_tests += 3;
            if (ld_input !== 1'b1) begin n_fail++; $display("FAIL wrap_issue: op %0d got %b expected 1", i, ld_input); end
            if (op_a !== exp_a || op_b !== exp_b) begin n_fail++; $display("FAIL wrap_order: op %0d got %0d/%0d expected %0d/%0d", i, op_a, op_b, exp_a, exp_b); end
            if (count !== 2) begin n_fail++; $display("FAIL wrap_count: op %0d got %0d expected 2", i, count); end
            in_valid  = 1'b0;
            mult_done = 1'b1;
            tick();
            mult_done = 1'b0;
            n_tests++;
            if (ld_input !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_block: op %0d got %b expected 0", i, ld_input); end
        end
    endtask

    task automatic test_reset_midop();
        logic [WIDTH-1:0] na;
        logic [WIDTH-1:0] nb;
        int pulses;
        model_on   = 1'b0;
        mult_ready = 1'b1;
        mult_done  = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (count !== 2) begin n_fail++; $display("FAIL midop_queued: got %0d expected 2", count); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_tests += 3;
        if (count !== 0)       begin n_fail++; $display("FAIL midop_count: got %0d expected 0", count); end
        if (empty !== 1'b1)    begin n_fail++; $display("FAIL midop_empty: got %b expected 1", empty); end
        if (ld_input !== 1'b0) begin n_fail++; $display("FAIL midop_ld: got %b expected 0", ld_input); end
        tick();
        na       = WIDTH'($urandom);
        nb       = WIDTH'($urandom);
        in_valid = 1'b1;
        in_a     = na;
        in_b     = nb;
        tick();
        in_valid = 1'b0;
        pulses   = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (ld_input === 1'b1) begin
                pulses++;
                n_tests++;
                if (op_a !== na || op_b !== nb) begin n_fail++; $display("FAIL midop_stale: got %0d/%0d expected %0d/%0d", op_a, op_b, na, nb); end
            end
        end
        n_tests += 2;
        if (pulses != 1) begin n_fail++; $display("FAIL midop_pulses: got %0d expected 1", pulses); end
        if (count !== 0) begin n_fail++; $display("FAIL midop_drain: got %0d expected 0", count); end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        tick_no    = 0;
        model_on   = 1'b0;
        mst        = M_IDLE;
        mcnt       = 0;
        done_tick  = -1;
        rbusy      = 1'b0;
        exp_ld     = 1'b0;
        exp_a      = '0;
        exp_b      = '0;
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        mult_ready = 1'b0;
        mult_done  = 1'b0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_full();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
